// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS CPU Avalon-MM memory bus.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } bus_resp_state_t;

  localparam int BYTE_LANES = 4;
  localparam int WORD_BYTES = 4;

  localparam int ERR_RW    = 0;
  localparam int ERR_ALIGN = 1;
  localparam int ERR_RANGE = 2;

endpackage

// File: rtl/mips_lfsr16.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1; steps once per cycle with advance high.
module mips_lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= seed;
    end else if (advance) begin
      value <= value[0] ? ({1'b0, value[15:1]} ^ 16'hB400) : {1'b0, value[15:1]};
    end
  end

endmodule

// File: rtl/mips_avalon_ram_responder.sv
// Avalon-MM word RAM responder: request to completion takes stall+2 cycles, one bubble between
// back-to-back transfers; waitrequest stalls are fixed or LFSR-random and errors are sticky.
module mips_avalon_ram_responder
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
  parameter int          DEPTH_LOG2  = 12,
  parameter int          WAIT_CYCLES = 2,
  parameter int          WAIT_MODE   = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic [2:0]  err_status
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  bus_resp_state_t state, state_nxt;
  logic [3:0]  count, count_nxt;
  logic [3:0]  stall_n;
  logic [15:0] lfsr;
  logic        lfsr_adv;

  logic        req;
  logic        rw_both;
  logic        misaligned;
  logic [29:0] word_idx;
  logic        in_range;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic        load_rdata;
  logic        xfer_done;
  logic        commit;

  logic [31:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  mips_lfsr16 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (lfsr_adv),
    .seed    (LFSR_SEED),
    .value   (lfsr)
  );

  assign req        = read | write;
  assign rw_both    = read & write;
  assign misaligned = (address[1:0] != 2'b00);

  // Wrapping subtract: addresses below BASE_ADDR land far out of range.
  assign word_idx = 30'((address - BASE_ADDR) >> $clog2(WORD_BYTES));
  assign in_range = (word_idx >> DEPTH_LOG2) == '0;
  assign ram_idx  = word_idx[DEPTH_LOG2-1:0];

  assign stall_n = (WAIT_MODE == 1) ? 4'(lfsr % 16'(WAIT_CYCLES + 1)) : 4'(WAIT_CYCLES);

  assign waitrequest = req && (state != ACK) && !rw_both;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    lfsr_adv  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req && !rw_both) begin
          lfsr_adv  = 1'b1;
          count_nxt = stall_n;
          state_nxt = (stall_n != 4'd0) ? BUSY : ACK;
        end
      end
      BUSY: begin
        if (!req || rw_both) begin
          state_nxt = IDLE;
        end else begin
          count_nxt = count - 4'd1;
          if (count == 4'd1) state_nxt = ACK;
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign load_rdata = read && !write && (state != ACK) && (state_nxt == ACK);
  assign xfer_done  = (state == ACK) && req && !rw_both;
  assign commit     = xfer_done && write && in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      readdata   <= '0;
      err_status <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (load_rdata) readdata <= in_range ? mem[ram_idx] : 32'h0;
      if (rw_both) err_status[ERR_RW] <= 1'b1;
      if (xfer_done) begin
        if (misaligned) err_status[ERR_ALIGN] <= 1'b1;
        if (!in_range)  err_status[ERR_RANGE] <= 1'b1;
      end
    end
  end

  // No reset on the array so it maps onto block RAM; reset only blocks the commit.
  always_ff @(posedge clk) begin
    if (!reset && commit) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (byteenable[i]) mem[ram_idx][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mips_avalon_ram_responder.sv
// Bench: three responders (fixed 2-cycle, zero-wait, random 0..7 stall) against tables and a model.
module tb_mips_avalon_ram_responder;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst [3];
  logic [31:0] adr [3];
  logic        rd  [3];
  logic        wr  [3];
  logic [31:0] wdat [3];
  logic [3:0]  be  [3];
  logic        wreq [3];
  logic [31:0] rdat [3];
  logic [2:0]  err [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mips_avalon_ram_responder #(.WAIT_CYCLES(2), .WAIT_MODE(0)) u_fix2 (
    .clk(clk), .reset(rst[0]), .address(adr[0]), .read(rd[0]), .write(wr[0]),
    .writedata(wdat[0]), .byteenable(be[0]), .waitrequest(wreq[0]),
    .readdata(rdat[0]), .err_status(err[0]));

  mips_avalon_ram_responder #(.WAIT_CYCLES(0), .WAIT_MODE(0)) u_fix0 (
    .clk(clk), .reset(rst[1]), .address(adr[1]), .read(rd[1]), .write(wr[1]),
    .writedata(wdat[1]), .byteenable(be[1]), .waitrequest(wreq[1]),
    .readdata(rdat[1]), .err_status(err[1]));

  mips_avalon_ram_responder #(.WAIT_CYCLES(7), .WAIT_MODE(1)) u_rnd (
    .clk(clk), .reset(rst[2]), .address(adr[2]), .read(rd[2]), .write(wr[2]),
    .writedata(wdat[2]), .byteenable(be[2]), .waitrequest(wreq[2]),
    .readdata(rdat[2]), .err_status(err[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One transfer: drive after a rising edge, count stalled cycles, capture readdata in the done cycle.
  task automatic xfer(input int d, input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] dat, input logic [3:0] lanes, input bit hold,
                      output int stalls, output logic [31:0] data_out);
    @(posedge clk); #1;
    adr[d] = a; rd[d] = r; wr[d] = w; wdat[d] = dat; be[d] = lanes;
    @(negedge clk);
    stalls = 0;
    while (wreq[d] && stalls < 40) begin
      @(negedge clk);
      stalls++;
    end
    if (wreq[d]) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout dut%0d: waitrequest still 1, expected 0", d);
    end
    data_out = rdat[d];
    @(posedge clk); #1;
    if (!hold) begin
      rd[d] = 1'b0;
      wr[d] = 1'b0;
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  typedef struct {
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [31:0] dat;
    logic [3:0]  lanes;
    logic [31:0] exp_rd;
    logic [2:0]  exp_err;
  } vec_t;

  vec_t        tbl [10];
  bit   [31:0] mdl [16];
  logic [15:0] mlfsr;
  logic [7:0]  seen;
  logic [2:0]  exp_err;
  int          st;
  logic [31:0] got;
  int          idx;
  logic [31:0] a;
  bit          oor, mis, r;
  logic [31:0] dat;
  logic [3:0]  lanes;

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    tbl[0] = '{1'b0, 1'b1, BASE,            32'hDEADBEEF, 4'hF,    32'h0,        3'b000};
    tbl[1] = '{1'b1, 1'b0, BASE,            32'h0,        4'hF,    32'hDEADBEEF, 3'b000};
    tbl[2] = '{1'b0, 1'b1, BASE + 32'h10,   32'h11223344, 4'hF,    32'h0,        3'b000};
    tbl[3] = '{1'b0, 1'b1, BASE + 32'h10,   32'hAABBCCDD, 4'b0101, 32'h0,        3'b000};
    tbl[4] = '{1'b1, 1'b0, BASE + 32'h10,   32'h0,        4'h0,    32'h11BB33DD, 3'b000};
    tbl[5] = '{1'b0, 1'b1, BASE + 32'h14,   32'h12345678, 4'h0,    32'h0,        3'b000};
    tbl[6] = '{1'b1, 1'b0, BASE + 32'h14,   32'h0,        4'hF,    32'h0,        3'b000};
    tbl[7] = '{1'b1, 1'b0, 32'h0000_0000,   32'h0,        4'hF,    32'h0,        3'b100};
    tbl[8] = '{1'b0, 1'b1, BASE + 32'h4,    32'hCAFEF00D, 4'hF,    32'h0,        3'b100};
    tbl[9] = '{1'b1, 1'b0, BASE + 32'h6,    32'h0,        4'hF,    32'hCAFEF00D, 3'b110};

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; adr[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0; wdat[d] = '0; be[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_wait%0d", d), 32'(wreq[d]), 32'h0);
      check($sformatf("reset_rdata%0d", d), rdat[d], 32'h0);
      check($sformatf("reset_err%0d", d), 32'(err[d]), 32'h0);
    end

    for (int i = 0; i < 10; i++) begin
      xfer(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].dat, tbl[i].lanes, 1'b0, st, got);
      check($sformatf("tbl%0d_stall", i), 32'(st), 32'd3);
      if (tbl[i].r) check($sformatf("tbl%0d_rdata", i), got, tbl[i].exp_rd);
      check($sformatf("tbl%0d_err", i), 32'(err[0]), 32'(tbl[i].exp_err));
    end

    // Write abandoned while stalled must leave RAM untouched.
    @(posedge clk); #1;
    adr[0] = BASE + 32'h20; wr[0] = 1'b1; wdat[0] = 32'h55555555; be[0] = 4'hF;
    @(negedge clk);
    check("abort_wait_idle", 32'(wreq[0]), 32'h1);
    @(negedge clk);
    check("abort_wait_busy", 32'(wreq[0]), 32'h1);
    @(posedge clk); #1;
    wr[0] = 1'b0;
    xfer(0, 1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'hF, 1'b0, st, got);
    check("abort_ram", got, 32'h0);

    // read and write together: released at once, flagged, no access.
    @(posedge clk); #1;
    adr[0] = BASE; rd[0] = 1'b1; wr[0] = 1'b1; wdat[0] = 32'h0; be[0] = 4'hF;
    @(negedge clk);
    check("rw_wait", 32'(wreq[0]), 32'h0);
    @(posedge clk); #1;
    rd[0] = 1'b0; wr[0] = 1'b0;
    check("rw_err", 32'(err[0]), 32'h7);
    xfer(0, 1'b1, 1'b0, BASE, 32'h0, 4'hF, 1'b0, st, got);
    check("rw_ram", got, 32'hDEADBEEF);

    // Zero-wait responder: single-cycle stall and a bubble between back-to-back reads.
    xfer(1, 1'b0, 1'b1, BASE, 32'h01010101, 4'hF, 1'b0, st, got);
    check("w0_stall", 32'(st), 32'd1);
    xfer(1, 1'b0, 1'b1, BASE + 32'h4, 32'h02020202, 4'hF, 1'b0, st, got);
    xfer(1, 1'b1, 1'b0, BASE, 32'h0, 4'hF, 1'b1, st, got);
    check("b2b_first_stall", 32'(st), 32'd1);
    check("b2b_first_rdata", got, 32'h01010101);
    adr[1] = BASE + 32'h4;
    @(negedge clk);
    check("b2b_bubble", 32'(wreq[1]), 32'h1);
    @(negedge clk);
    check("b2b_second_wait", 32'(wreq[1]), 32'h0);
    check("b2b_second_rdata", rdat[1], 32'h02020202);
    @(posedge clk); #1;
    rd[1] = 1'b0;

    // Random traffic on the LFSR-stalled responder.
    mlfsr = 16'hACE1;
    seen = '0;
    exp_err = '0;
    for (int k = 0; k < 1000; k++) begin
      idx = $urandom_range(0, 15);
      oor = ($urandom_range(0, 15) == 0);
      mis = ($urandom_range(0, 7) == 0);
      a = oor ? (BASE + 32'h0001_0000 + 32'(idx) * 4) : (BASE + 32'(idx) * 4);
      if (mis) a[1:0] = 2'($urandom_range(1, 3));
      r = 1'($urandom_range(0, 1));
      dat = $urandom;
      lanes = 4'($urandom);
      xfer(2, r, !r, a, dat, lanes, 1'b0, st, got);
      check("rnd_stall", 32'(st), 32'(mlfsr % 16'd8) + 32'd1);
      mlfsr = lfsr_step(mlfsr);
      if (st >= 1 && st <= 8) seen[st-1] = 1'b1;
      if (r) begin
        check("rnd_rdata", got, oor ? 32'h0 : mdl[idx]);
      end else if (!oor) begin
        for (int l = 0; l < 4; l++) if (lanes[l]) mdl[idx][8*l +: 8] = dat[8*l +: 8];
      end
      exp_err = exp_err | {oor, mis, 1'b0};
    end
    check("rnd_stalls_seen", 32'(seen), 32'hFF);
    check("rnd_err", 32'(err[2]), 32'(exp_err));

    // Reset while a write is stalled: back to idle, errors cleared, nothing written.
    while ((mlfsr % 16'd8) == 16'd0) begin
      xfer(2, 1'b1, 1'b0, BASE, 32'h0, 4'hF, 1'b0, st, got);
      mlfsr = lfsr_step(mlfsr);
    end
    @(posedge clk); #1;
    adr[2] = BASE + 32'h14; wr[2] = 1'b1; wdat[2] = 32'h0BADF00D; be[2] = 4'hF;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(negedge clk);
    check("rst_busy_wait", 32'(wreq[2]), 32'h1);
    @(posedge clk); #1;
    rst[2] = 1'b0; wr[2] = 1'b0;
    check("rst_err", 32'(err[2]), 32'h0);
    check("rst_rdata", rdat[2], 32'h0);
    @(negedge clk);
    check("rst_idle_wait", 32'(wreq[2]), 32'h0);
    mlfsr = 16'hACE1;
    xfer(2, 1'b1, 1'b0, BASE + 32'h14, 32'h0, 4'hF, 1'b0, st, got);
    check("rst_stall", 32'(st), 32'(mlfsr % 16'd8) + 32'd1);
    check("rst_ram", got, mdl[5]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
